// File: rtl/bias_act_pipe.sv
// bias_act_pipe: per-lane bias add with saturation, rounding right-shift
// requantisation and a selectable activation. The pipeline has four
// register ranks: capture (biased sum), round add, shift, and output
// (activation plus saturation). Configuration travels with each beat.
module bias_act_pipe #(
   parameter int ARRAY_N   = 16,
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            bias_wr_en,
   input  logic [$clog2(ARRAY_N)-1:0]      bias_wr_idx,
   input  logic [IN_WIDTH-1:0]             bias_wr_data,
   input  logic [1:0]                      cfg_mode,
   input  logic [4:0]                      cfg_shift,
   input  logic [OUT_WIDTH-1:0]            cfg_clip_max,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ARRAY_N*IN_WIDTH-1:0]     data_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ARRAY_N*OUT_WIDTH-1:0]    data_out,
   output logic                            busy
);

   typedef logic signed [IN_WIDTH-1:0]  in_t;
   typedef logic signed [IN_WIDTH:0]    wide_t;
   typedef logic signed [OUT_WIDTH-1:0] out_t;

   localparam wide_t OUT_MAX_W = {{(IN_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam wide_t OUT_MIN_W = {{(IN_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0] CLIP_LIM = {1'b0, {(OUT_WIDTH-1){1'b1}}};

   // Saturate a one-bit-wider sum back into the signed input range.
   function automatic in_t sat_in(input wide_t v);
      in_t r;
      if (v[IN_WIDTH] != v[IN_WIDTH-1]) begin
         r = v[IN_WIDTH] ? {1'b1, {(IN_WIDTH-1){1'b0}}} : {1'b0, {(IN_WIDTH-1){1'b1}}};
      end else begin
         r = v[IN_WIDTH-1:0];
      end
      return r;
   endfunction

   // Saturate into the signed output range.
   function automatic out_t sat_out(input wide_t v);
      out_t r;
      if (v > OUT_MAX_W) begin
         r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else if (v < OUT_MIN_W) begin
         r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         r = v[OUT_WIDTH-1:0];
      end
      return r;
   endfunction

   // Activation on the requantised value; clip bound is already limited.
   function automatic wide_t activate(input wide_t x, input logic [1:0] mode,
                                      input logic [OUT_WIDTH-1:0] clip);
      wide_t cmax;
      wide_t y;
      cmax = wide_t'({{(IN_WIDTH+1-OUT_WIDTH){1'b0}}, clip});
      case (mode)
         2'b00: y = x;
         2'b01: y = x[IN_WIDTH] ? wide_t'(0) : x;
         2'b10: begin
            if (x[IN_WIDTH]) begin
               y = wide_t'(0);
            end else if (x > cmax) begin
               y = cmax;
            end else begin
               y = x;
            end
         end
         2'b11: y = x[IN_WIDTH] ? (x >>> 3) : x;
         default: y = x;
      endcase
      return y;
   endfunction

   in_t                   bias_r   [ARRAY_N];
   in_t                   s1_d_r   [ARRAY_N];
   wide_t                 s2_d_r   [ARRAY_N];
   wide_t                 s3_d_r   [ARRAY_N];
   out_t                  o_d_r    [ARRAY_N];
   in_t                   s1_nxt_s [ARRAY_N];
   wide_t                 s2_nxt_s [ARRAY_N];
   wide_t                 s3_nxt_s [ARRAY_N];
   out_t                  o_nxt_s  [ARRAY_N];
   logic                  s1_v_r, s2_v_r, s3_v_r, o_v_r;
   logic [1:0]            s1_mode_r, s2_mode_r, s3_mode_r;
   logic [4:0]            s1_shift_r, s2_shift_r;
   logic [OUT_WIDTH-1:0]  s1_clip_r, s2_clip_r, s3_clip_r;
   logic [OUT_WIDTH-1:0]  clip_eff_s;
   wide_t                 rnd_s;
   logic                  adv_s, move_s, accept_s;

   // Handshake: whole pipe advances unless the output is held; flush blocks intake.
   always_comb begin
      adv_s    = !o_v_r || out_ready;
      move_s   = adv_s && !flush;
      in_ready = adv_s && !flush && reset_n;
      accept_s = in_valid && in_ready;
      busy     = s1_v_r || s2_v_r || s3_v_r || o_v_r;
      out_valid = o_v_r;
   end

   // Per-lane datapath for every stage, plus output packing.
   always_comb begin
      data_out = '0;
      if (cfg_clip_max > CLIP_LIM) begin
         clip_eff_s = CLIP_LIM;
      end else begin
         clip_eff_s = cfg_clip_max;
      end
      if (s1_shift_r != 5'd0) begin
         rnd_s = wide_t'(1) << (s1_shift_r - 5'd1);
      end else begin
         rnd_s = wide_t'(0);
      end
      for (int i = 0; i < ARRAY_N; i++) begin
         s1_nxt_s[i] = sat_in(wide_t'(in_t'(data_in[IN_WIDTH*i +: IN_WIDTH])) + wide_t'(bias_r[i]));
         s2_nxt_s[i] = wide_t'(s1_d_r[i]) + rnd_s;
         s3_nxt_s[i] = s2_d_r[i] >>> s2_shift_r;
         o_nxt_s[i]  = sat_out(activate(s3_d_r[i], s3_mode_r, s3_clip_r));
         data_out[OUT_WIDTH*i +: OUT_WIDTH] = o_d_r[i];
      end
   end

   // Bias register file; out-of-range lane indices are ignored.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ARRAY_N; i++) bias_r[i] <= '0;
      end else if (bias_wr_en && (int'(bias_wr_idx) < ARRAY_N)) begin
         bias_r[bias_wr_idx] <= bias_wr_data;
      end
   end

   // Valid bits: reset and flush drop every beat, otherwise shift on advance.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         s1_v_r <= 1'b0;
         s2_v_r <= 1'b0;
         s3_v_r <= 1'b0;
         o_v_r  <= 1'b0;
      end else if (adv_s) begin
         s1_v_r <= accept_s;
         s2_v_r <= s1_v_r;
         s3_v_r <= s2_v_r;
         o_v_r  <= s3_v_r;
      end
   end

   // Stage data: each rank loads only when a valid beat moves into it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ARRAY_N; i++) begin
            s1_d_r[i] <= '0;
            s2_d_r[i] <= '0;
            s3_d_r[i] <= '0;
            o_d_r[i]  <= '0;
         end
         s1_mode_r  <= 2'd0;
         s2_mode_r  <= 2'd0;
         s3_mode_r  <= 2'd0;
         s1_shift_r <= 5'd0;
         s2_shift_r <= 5'd0;
         s1_clip_r  <= '0;
         s2_clip_r  <= '0;
         s3_clip_r  <= '0;
      end else begin
         if (accept_s) begin
            s1_d_r     <= s1_nxt_s;
            s1_mode_r  <= cfg_mode;
            s1_shift_r <= cfg_shift;
            s1_clip_r  <= clip_eff_s;
         end
         if (move_s && s1_v_r) begin
            s2_d_r     <= s2_nxt_s;
            s2_mode_r  <= s1_mode_r;
            s2_shift_r <= s1_shift_r;
            s2_clip_r  <= s1_clip_r;
         end
         if (move_s && s2_v_r) begin
            s3_d_r     <= s3_nxt_s;
            s3_mode_r  <= s2_mode_r;
            s3_clip_r  <= s2_clip_r;
         end
         if (move_s && s3_v_r) begin
            o_d_r      <= o_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_bias_act_pipe.sv
// Self-checking bench for bias_act_pipe with a 4-lane instance.
module tb_bias_act_pipe;

   localparam longint IMAX = 64'sd2147483647;
   localparam longint IMIN = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          reset_n, bias_wr_en, flush, in_valid, in_ready;
   logic          out_valid, out_ready, busy;
   logic [1:0]    bias_wr_idx, cfg_mode;
   logic [4:0]    cfg_shift;
   logic [31:0]   bias_wr_data;
   logic [15:0]   cfg_clip_max;
   logic [127:0]  data_in;
   logic [63:0]   data_out;

   int            checks = 0;
   int            errors = 0;

   longint        m_bias [4];
   bit            m_v    [4];
   logic [15:0]   m_d    [4][4];
   bit            m_acc;

   always #5 clk = ~clk;

   bias_act_pipe #(.ARRAY_N(4), .IN_WIDTH(32), .OUT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .bias_wr_en(bias_wr_en),
      .bias_wr_idx(bias_wr_idx), .bias_wr_data(bias_wr_data),
      .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .cfg_clip_max(cfg_clip_max),
      .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .busy(busy)
   );

   // Whole-beat reference: bias, saturate, round/shift, activate, saturate.
   function automatic logic [15:0] ref_out(input longint x, input longint b,
                                           input int mode, input int sh, input int clip);
      longint s, y, cm;
      s = x + b;
      if (s > IMAX) s = IMAX;
      if (s < IMIN) s = IMIN;
      if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
      case (mode)
         0: y = s;
         1: y = (s < 0) ? 0 : s;
         2: begin
            cm = (clip > 32767) ? 32767 : clip;
            y = (s < 0) ? 0 : ((s > cm) ? cm : s);
         end
         default: y = (s >= 0) ? s : -((-s + 7) / 8);
      endcase
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return 16'(y);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance the reference by one clock edge using the currently driven inputs.
   task automatic model_step();
      bit adv;
      m_acc = 1'b0;
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            m_v[k] = 1'b0;
            m_bias[k] = 0;
            for (int l = 0; l < 4; l++) m_d[k][l] = 16'd0;
         end
      end else begin
         adv = !m_v[3] || out_ready;
         if (flush) begin
            for (int k = 0; k < 4; k++) m_v[k] = 1'b0;
         end else if (adv) begin
            for (int k = 3; k > 0; k--) begin
               if (m_v[k-1]) m_d[k] = m_d[k-1];
               m_v[k] = m_v[k-1];
            end
            m_v[0] = in_valid;
            m_acc  = in_valid;
            if (in_valid)
               for (int l = 0; l < 4; l++)
                  m_d[0][l] = ref_out(longint'($signed(data_in[32*l +: 32])), m_bias[l],
                                      int'(cfg_mode), int'(cfg_shift), int'(cfg_clip_max));
         end
         if (bias_wr_en) m_bias[bias_wr_idx] = longint'($signed(bias_wr_data));
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(m_v[3]));
      chk("busy", 32'(busy), 32'(m_v[0] | m_v[1] | m_v[2] | m_v[3]));
      chk("in_ready", 32'(in_ready), 32'(reset_n && (!m_v[3] || out_ready) && !flush));
      for (int l = 0; l < 4; l++)
         chk($sformatf("lane%0d", l), 32'(data_out[16*l +: 16]), 32'(m_d[3][l]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_lanes(input int a, input int b, input int c, input int d);
      data_in = {32'(d), 32'(c), 32'(b), 32'(a)};
   endtask

   task automatic wr_bias(input int idx, input int val);
      bias_wr_en = 1'b1;
      bias_wr_idx = 2'(idx);
      bias_wr_data = 32'(val);
      tick();
      bias_wr_en = 1'b0;
   endtask

   task automatic send_and_drain(input int a, input int b, input int c, input int d);
      set_lanes(a, b, c, d);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
   endtask

   task automatic rand_cfg();
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_shift = 5'($urandom_range(0, 31));
      cfg_clip_max = 16'($urandom);
      data_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, cyc, hs;
      reset_n = 1'b0; bias_wr_en = 1'b0; bias_wr_idx = 2'd0; bias_wr_data = 32'd0;
      cfg_mode = 2'd0; cfg_shift = 5'd0; cfg_clip_max = 16'd0; flush = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Basic ReLU
      wr_bias(0, 10); wr_bias(1, -10); wr_bias(2, 0); wr_bias(3, -5);
      cfg_mode = 2'b01; cfg_shift = 5'd0;
      send_and_drain(5, 5, -3, 5);
      chk("relu_valid", 32'(out_valid), 32'd1);
      chk("relu_l0", 32'(data_out[15:0]), 32'd15);
      chk("relu_l1", 32'(data_out[31:16]), 32'd0);
      chk("relu_l3", 32'(data_out[63:48]), 32'd0);

      // Rounding and saturation
      wr_bias(0, 32'h100); wr_bias(1, 0); wr_bias(2, 0); wr_bias(3, 0);
      cfg_mode = 2'b00; cfg_shift = 5'd4;
      send_and_drain(int'(32'h7FFFFFF0), 24, 24, -24);
      chk("sat_l0", 32'(data_out[15:0]), 32'h7FFF);
      chk("round_l1", 32'(data_out[31:16]), 32'd2);
      chk("round_l3", 32'(data_out[63:48]), 32'hFFFF);

      // Clip and leaky
      wr_bias(0, 0);
      cfg_mode = 2'b10; cfg_shift = 5'd0; cfg_clip_max = 16'd6;
      send_and_drain(9, -4, 3, 100);
      chk("clip_hi", 32'(data_out[15:0]), 32'd6);
      chk("clip_neg", 32'(data_out[31:16]), 32'd0);
      cfg_clip_max = 16'hFFFF;
      send_and_drain(40000, 12345, -1, 0);
      chk("clip_lim", 32'(data_out[15:0]), 32'h7FFF);
      cfg_mode = 2'b11;
      send_and_drain(-17, 17, -8, -1);
      chk("leaky_neg", 32'(data_out[15:0]), 32'hFFFD);
      chk("leaky_pos", 32'(data_out[31:16]), 32'd17);

      // Backpressure with randomized beats and biases
      for (int l = 0; l < 4; l++) wr_bias(l, $urandom_range(0, 2000) - 1000);
      sent = 0; cyc = 0; hs = 0;
      rand_cfg();
      while ((sent < 8 || m_v[0] || m_v[1] || m_v[2] || m_v[3]) && cyc < 200) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         in_valid = (sent < 8);
         if (out_valid === 1'b1 && out_ready) hs++;
         tick();
         if (m_acc) begin
            sent++;
            rand_cfg();
         end
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_timeout", 32'(cyc < 200), 32'd1);
      chk("bp_count", 32'(hs), 32'd8);

      // Config isolation: bias and mode change on the acceptance edge
      for (int l = 0; l < 4; l++) wr_bias(l, 0);
      cfg_shift = 5'd0;
      cfg_mode = 2'b01;
      set_lanes(3, -20, 4, -7);
      in_valid = 1'b1;
      bias_wr_en = 1'b1; bias_wr_idx = 2'd1; bias_wr_data = 32'd5;
      tick();
      bias_wr_en = 1'b0;
      cfg_mode = 2'b00;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("iso_old", 32'(data_out[31:16]), 32'd0);
      tick();
      chk("iso_new", 32'(data_out[31:16]), 32'hFFF1);

      // Flush with three beats in flight; biases must survive
      wr_bias(0, 7); wr_bias(1, -9); wr_bias(2, 100); wr_bias(3, -1);
      in_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      flush = 1'b1;
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_busy", 32'(busy), 32'd0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      cfg_mode = 2'b00; cfg_shift = 5'd0;
      send_and_drain(0, 0, 0, 0);
      chk("keep_b0", 32'(data_out[15:0]), 32'd7);
      chk("keep_b1", 32'(data_out[31:16]), 32'hFFF7);
      chk("keep_b2", 32'(data_out[47:32]), 32'd100);

      // Reset mid-stream: takes priority over flush, writes and acceptance
      in_valid = 1'b1;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      tick(); tick();
      reset_n = 1'b0; flush = 1'b1; bias_wr_en = 1'b1; bias_wr_idx = 2'd2; bias_wr_data = 32'd55;
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1; flush = 1'b0; bias_wr_en = 1'b0; in_valid = 1'b0;
      tick();
      send_and_drain(0, 0, 0, 0);
      chk("rst_out_valid", 32'(out_valid), 32'd1);
      chk("rst_bias", 32'(data_out), 32'd0);
      chk("rst_bias_hi", 32'(data_out[63:32]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bias_act_pipe.md
BIAS_ACT_PIPE -- requirements
Module: bias_act_pipe

Interface
REQ-001 SHALL have parameter ARRAY_N, default 16: number of parallel lanes.
REQ-002 SHALL have parameter IN_WIDTH, default 32: signed accumulator width per lane.
REQ-003 SHALL have parameter OUT_WIDTH, default 16: signed result width per lane; OUT_WIDTH <= IN_WIDTH.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port bias_wr_en, input, 1: bias write strobe.
REQ-007 SHALL have port bias_wr_idx, input, $clog2(ARRAY_N): lane to write; values >= ARRAY_N are ignored.
REQ-008 SHALL have port bias_wr_data, input, IN_WIDTH: signed bias value.
REQ-009 SHALL have port cfg_mode, input, 2: activation mode (00 bypass, 01 ReLU, 10 clip, 11 leaky).
REQ-010 SHALL have port cfg_shift, input, 5: requantisation right-shift amount, 0..31.
REQ-011 SHALL have port cfg_clip_max, input, OUT_WIDTH: unsigned upper bound used in clip mode.
REQ-012 SHALL have port flush, input, 1: synchronous pipeline clear.
REQ-013 SHALL have port in_valid, input, 1: data_in beat is valid.
REQ-014 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-015 SHALL have port data_in, input, ARRAY_N*IN_WIDTH: packed signed lanes; lane i occupies bits [IN_WIDTH*(i+1)-1 : IN_WIDTH*i].
REQ-016 SHALL have port out_valid, output, 1: data_out beat is valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts a beat.
REQ-018 SHALL have port data_out, output, ARRAY_N*OUT_WIDTH: packed signed results, same lane order as data_in.
REQ-019 SHALL have port busy, output, 1: high when any pipeline stage holds a valid beat.

Function
REQ-020 SHALL hold one IN_WIDTH bias register per lane; bias_wr_en=1 writes bias_wr_data into lane bias_wr_idx at the clock edge.
REQ-021 SHALL be a 3-stage pipeline with global advance enable adv = !out_valid | out_ready; in_ready = adv; a beat is accepted when in_valid & in_ready.
REQ-022 SHALL present a beat accepted at edge t on data_out with out_valid=1 after edge t+3, provided adv=1 throughout; latency is 3 cycles.
REQ-023 SHALL freeze all stage registers and valid bits when adv=0; data_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, in stage 1, compute per-lane data_in + bias in IN_WIDTH+1 bits and saturate the result to the signed IN_WIDTH range.
REQ-025 SHALL, in stage 2, add round constant 2^(shift-1) (0 when shift=0) in IN_WIDTH+1 bits, then arithmetic right shift by shift.
REQ-026 SHALL, in stage 3, apply activation: bypass x; ReLU max(x,0); clip min(max(x,0),cfg_clip_max); leaky x if x>=0 else x>>>3 (floor); then saturate to the signed OUT_WIDTH range.
REQ-027 SHALL sample the bias array, cfg_mode, cfg_shift and cfg_clip_max at the acceptance edge and carry them with the beat; later config changes SHALL NOT affect beats already accepted.
REQ-028 SHALL, when a bias write and an acceptance occur on the same edge, use the pre-write bias for that beat.
REQ-029 SHALL, when flush=1, clear all stage valid bits at the edge, drop in-flight beats, and retain bias registers; a beat presented with flush=1 SHALL NOT be accepted (in_ready=0 while flush=1).
REQ-030 SHALL treat cfg_clip_max values above 2^(OUT_WIDTH-1)-1 as 2^(OUT_WIDTH-1)-1.

Reset
REQ-031 SHALL, when reset_n=0 at a rising edge, clear all bias registers to 0, all stage valid bits to 0, and all stage data to 0.
REQ-032 SHALL drive out_valid=0, busy=0 and data_out=0 from the edge after reset until the first beat completes; in_ready=1 once reset_n=1.
REQ-033 SHALL discard in-flight beats when reset is asserted mid-operation; reset SHALL take priority over flush, bias writes and acceptance.

Verification
REQ-034 SHALL cover basic ReLU: ARRAY_N=4, biases {10,-10,0,-5}, shift=0, mode=01, data_in {5,5,-3,5} -> data_out {15,0,0,0}, three cycles after acceptance.
REQ-035 SHALL cover rounding and saturation: shift=4, mode=00, bias 0, data_in 24 -> 2; data_in 0x7FFFFFF0 with bias 0x100 -> IN saturates to 0x7FFFFFFF, output saturates to 32767.
REQ-036 SHALL cover clip and leaky: clip_max=6, input 9 -> 6 and -4 -> 0; leaky mode, input -17 -> -3.
REQ-037 SHALL cover backpressure: stream 8 beats with out_ready toggling 1,0,0,1 -> all 8 emerge in order, none duplicated or lost, data_out stable while stalled.
REQ-038 SHALL cover config isolation: change bias and mode on the edge a beat is accepted -> that beat uses old values, the next beat uses new values.
REQ-039 SHALL cover flush and reset mid-stream: assert flush with 3 beats in flight -> out_valid=0 and busy=0 next cycle, biases unchanged; reset_n=0 mid-stream -> all biases read back as 0.
